icache_assoc: RTL

Parametrised set-associative instruction cache between the fetch stage (datapath side) and the memory controller/arbiter (cache-control side). It serves single-word instruction reads as a combinational hit. On a miss it runs a multi-word block fill and replaces the least-recently-used way of the indexed set. It also supports whole-cache invalidation and counts hits and misses for performance measurement.

---
 rtl/icache_assoc_pkg.sv | 11 +
 rtl/icache_assoc_lru.sv | 62 ++++++
 rtl/icache_assoc.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/icache_assoc_pkg.sv
// Shared types for the set-associative instruction cache.
package icache_assoc_pkg;

    // Miss-handling state machine: idle lookup, block fill from memory, line install.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_assoc_lru.sv
// Per-set true-LRU tracker built from per-way age counters (0 = most recent).
module icache_lru #(
    parameter int WAYS = 2,
    parameter int WAYW = 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            clear_i,
    input  logic            access_i,
    input  logic [WAYW-1:0] access_way_i,
    input  logic [WAYS-1:0] valid_i,
    output logic [WAYW-1:0] victim_o
);

    logic [WAYW-1:0] age_q [WAYS];

    // Age update: the accessed way becomes youngest and every way not older than it ages
    // by one; ageing equal-aged ways lets the all-zero starting state settle into a
    // strict ordering as ways are touched, saturating at the oldest age.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= '0;
        end else if (clear_i) begin
            for (int w = 0; w < WAYS; w++) age_q[w] <= '0;
        end else if (access_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAYW'(w) == access_way_i) begin
                    age_q[w] <= '0;
                end else if ((age_q[w] <= age_q[access_way_i]) &&
                             (age_q[w] != WAYW'(WAYS - 1))) begin
                    age_q[w] <= age_q[w] + WAYW'(1);
                end
            end
        end
    end

    // Victim choice: lowest-numbered invalid way, otherwise the oldest way (lowest index on a tie).
    always_comb begin
        logic [WAYW-1:0] oldest;
        logic [WAYW-1:0] oldest_age;
        logic [WAYW-1:0] invalid_way;
        logic            have_invalid;
        oldest       = '0;
        oldest_age   = '0;
        invalid_way  = '0;
        have_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[w] > oldest_age) begin
                oldest     = WAYW'(w);
                oldest_age = age_q[w];
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) begin
                invalid_way  = WAYW'(w);
                have_invalid = 1'b1;
            end
        end
        victim_o = have_invalid ? invalid_way : oldest;
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, LRU replacement,
// multi-word block fill from memory, whole-cache flush and hit/miss counters.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN_i,
    input  logic [31:0] imemaddr_i,
    input  logic        iflush_i,
    output logic        ihit_o,
    output logic [31:0] imemload_o,
    output logic        iREN_o,
    output logic [31:0] iaddr_o,
    input  logic        iwait_i,
    input  logic [31:0] iload_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    localparam int OB   = $clog2(WORDS);
    localparam int IB   = $clog2(SETS);
    localparam int TB   = 30 - OB - IB;
    localparam int OBW  = (OB > 0) ? OB : 1;
    localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Saturating 32-bit counter increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Line storage
    logic [WAYS-1:0] valid_q [SETS];
    logic [TB-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];

    // Miss handling registers
    icache_state_t   state_q;
    logic [31:0]     linebuf_q [WORDS];
    logic [IB-1:0]   fill_idx_q;
    logic [TB-1:0]   fill_tag_q;
    logic [WAYW-1:0] victim_q;
    logic [OBW-1:0]  beat_q;
    logic            iREN_q;
    logic [31:0]     iaddr_q;
    logic [31:0]     hit_count_q;
    logic [31:0]     miss_count_q;

    // Request decode
    logic [IB-1:0]   req_idx;
    logic [TB-1:0]   req_tag;
    logic [OBW-1:0]  req_woff;
    logic [31:0]     req_base;
    logic            hit_any;
    logic [WAYW-1:0] hit_way;
    logic            ihit;
    logic            beat_done;
    logic [WAYW-1:0] lru_way;
    logic [WAYW-1:0] set_victim [SETS];

    assign req_idx   = imemaddr_i[2 + OB +: IB];
    assign req_tag   = imemaddr_i[2 + OB + IB +: TB];
    assign req_woff  = (OB > 0) ? imemaddr_i[2 +: OBW] : '0;
    assign req_base  = imemaddr_i & ~32'(WORDS * 4 - 1);
    assign beat_done = iREN_q && !iwait_i;

    // Tag compare across every way of the indexed set.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAYW'(w);
            end
        end
    end

    assign ihit         = imemREN_i && (state_q == IDLE) && hit_any;
    assign ihit_o       = ihit;
    assign imemload_o   = ihit ? data_q[req_idx][hit_way][req_woff] : 32'd0;
    assign iREN_o       = iREN_q;
    assign iaddr_o      = iaddr_q;
    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;

    // A hit and a line install never coincide, so one shared way bus feeds every set's tracker.
    assign lru_way = (state_q == WRITE) ? victim_q : hit_way;

    genvar s;
    generate
        for (s = 0; s < SETS; s++) begin : g_lru
            logic acc;
            assign acc = !iflush_i &&
                         (((state_q == WRITE) && (fill_idx_q == IB'(s))) ||
                          (ihit && (req_idx == IB'(s))));
            icache_lru #(
                .WAYS (WAYS),
                .WAYW (WAYW)
            ) u_lru (
                .CLK          (CLK),
                .nRST         (nRST),
                .clear_i      (iflush_i),
                .access_i     (acc),
                .access_way_i (lru_way),
                .valid_i      (valid_q[s]),
                .victim_o     (set_victim[s])
            );
        end
    endgenerate

    // Miss FSM: latches the block and victim on a miss, streams beats into the line
    // buffer, then spends one cycle installing; flush aborts from any state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            iREN_q       <= 1'b0;
            iaddr_q      <= '0;
            beat_q       <= '0;
            fill_idx_q   <= '0;
            fill_tag_q   <= '0;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int k = 0; k < WORDS; k++) linebuf_q[k] <= '0;
        end else if (iflush_i) begin
            state_q <= IDLE;
            iREN_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ihit) begin
                        hit_count_q <= sat_inc(hit_count_q);
                    end else if (imemREN_i && !hit_any) begin
                        state_q      <= FILL;
                        iREN_q       <= 1'b1;
                        iaddr_q      <= req_base;
                        beat_q       <= '0;
                        fill_idx_q   <= req_idx;
                        fill_tag_q   <= req_tag;
                        victim_q     <= set_victim[req_idx];
                        miss_count_q <= sat_inc(miss_count_q);
                    end
                end
                FILL: begin
                    if (beat_done) begin
                        linebuf_q[beat_q] <= iload_i;
                        if (beat_q == OBW'(WORDS - 1)) begin
                            state_q <= WRITE;
                            iREN_q  <= 1'b0;
                        end else begin
                            beat_q  <= beat_q + OBW'(1);
                            iaddr_q <= iaddr_q + 32'd4;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    iREN_q  <= 1'b0;
                end
            endcase
        end
    end

    // Line array: flush drops every valid bit; the install cycle writes buffer, tag and valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[i][w] <= '0;
                    for (int k = 0; k < WORDS; k++) data_q[i][w][k] <= '0;
                end
            end
        end else if (iflush_i) begin
            for (int i = 0; i < SETS; i++) valid_q[i] <= '0;
        end else if (state_q == WRITE) begin
            valid_q[fill_idx_q][victim_q] <= 1'b1;
            tag_q[fill_idx_q][victim_q]   <= fill_tag_q;
            for (int k = 0; k < WORDS; k++) data_q[fill_idx_q][victim_q][k] <= linebuf_q[k];
        end
    end

endmodule
